id_ex_register: RTL and testbench

ID_EX_REGISTER -- requirements
Module: id_ex_register

---
 rtl/id_ex_register.sv | 125 ++++++++++++
 tb/tb_id_ex_register.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_register.sv
// ID/EX pipeline register: one-cycle stage between decode and execute.
// Flush (and an invalid decode slot) loads a bubble; stall holds the stage.
// All outputs come straight from flops, so no input reaches an output
// combinationally.
module id_ex_register #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic              id_reg_write,
    input  logic              id_mem_to_reg,
    input  logic              id_branch,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_reg_dst,
    input  logic              id_alu_src,
    input  logic [1:0]        id_alu_op,
    input  logic [5:0]        id_func,
    input  logic [REG_AW-1:0] id_shamt,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [DATA_W-1:0] id_rdata1,
    input  logic [DATA_W-1:0] id_rdata2,
    input  logic [DATA_W-1:0] id_imm_ext,
    input  logic [DATA_W-1:0] id_pc4,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_mem_to_reg,
    output logic              ex_branch,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_reg_dst,
    output logic              ex_alu_src,
    output logic [1:0]        ex_alu_op,
    output logic [5:0]        ex_func,
    output logic [REG_AW-1:0] ex_shamt,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_rd,
    output logic [DATA_W-1:0] ex_rdata1,
    output logic [DATA_W-1:0] ex_rdata2,
    output logic [DATA_W-1:0] ex_imm_ext,
    output logic [DATA_W-1:0] ex_pc4
);

    // Control bundle: everything that must read as zero in a bubble.
    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       mem_to_reg;
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       reg_dst;
        logic       alu_src;
        logic [1:0] alu_op;
    } ctrl_t;

    // Payload bundle: passes through even when the decode slot is invalid.
    typedef struct packed {
        logic [5:0]        func;
        logic [REG_AW-1:0] shamt;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] rdata1;
        logic [DATA_W-1:0] rdata2;
        logic [DATA_W-1:0] imm_ext;
        logic [DATA_W-1:0] pc4;
    } data_t;

    ctrl_t id_ctrl, ex_ctrl;
    data_t id_data, ex_data;

    // Gather decode-side fields into the bundles.
    always_comb begin
        id_ctrl = '{valid: id_valid, reg_write: id_reg_write,
                    mem_to_reg: id_mem_to_reg, branch: id_branch,
                    mem_read: id_mem_read, mem_write: id_mem_write,
                    reg_dst: id_reg_dst, alu_src: id_alu_src,
                    alu_op: id_alu_op};
        id_data = '{func: id_func, shamt: id_shamt, rs: id_rs, rt: id_rt,
                    rd: id_rd, rdata1: id_rdata1, rdata2: id_rdata2,
                    imm_ext: id_imm_ext, pc4: id_pc4};
    end

    // Stage register: reset > flush > stall > load (bubble controls if invalid).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_ctrl <= '0;
            ex_data <= '0;
        end else if (flush) begin
            ex_ctrl <= '0;
            ex_data <= '0;
        end else if (!stall) begin
            ex_ctrl <= id_valid ? id_ctrl : '0;
            ex_data <= id_data;
        end
    end

    assign ex_valid      = ex_ctrl.valid;
    assign ex_reg_write  = ex_ctrl.reg_write;
    assign ex_mem_to_reg = ex_ctrl.mem_to_reg;
    assign ex_branch     = ex_ctrl.branch;
    assign ex_mem_read   = ex_ctrl.mem_read;
    assign ex_mem_write  = ex_ctrl.mem_write;
    assign ex_reg_dst    = ex_ctrl.reg_dst;
    assign ex_alu_src    = ex_ctrl.alu_src;
    assign ex_alu_op     = ex_ctrl.alu_op;
    assign ex_func       = ex_data.func;
    assign ex_shamt      = ex_data.shamt;
    assign ex_rs         = ex_data.rs;
    assign ex_rt         = ex_data.rt;
    assign ex_rd         = ex_data.rd;
    assign ex_rdata1     = ex_data.rdata1;
    assign ex_rdata2     = ex_data.rdata2;
    assign ex_imm_ext    = ex_data.imm_ext;
    assign ex_pc4        = ex_data.pc4;

endmodule

// File: tb/tb_id_ex_register.sv
// Directed bench for id_ex_register: pass-through, stall hold, flush,
// flush+stall, async reset, invalid decode.
module tb_id_ex_register;
    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    logic clk = 1'b0;
    logic rst_n, stall, flush, id_valid;
    logic id_reg_write, id_mem_to_reg, id_branch, id_mem_read, id_mem_write;
    logic id_reg_dst, id_alu_src;
    logic [1:0] id_alu_op;
    logic [5:0] id_func;
    logic [REG_AW-1:0] id_shamt, id_rs, id_rt, id_rd;
    logic [DATA_W-1:0] id_rdata1, id_rdata2, id_imm_ext, id_pc4;
    logic ex_valid, ex_reg_write, ex_mem_to_reg, ex_branch, ex_mem_read;
    logic ex_mem_write, ex_reg_dst, ex_alu_src;
    logic [1:0] ex_alu_op;
    logic [5:0] ex_func;
    logic [REG_AW-1:0] ex_shamt, ex_rs, ex_rt, ex_rd;
    logic [DATA_W-1:0] ex_rdata1, ex_rdata2, ex_imm_ext, ex_pc4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    id_ex_register #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_reg_write(id_reg_write),
        .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_reg_dst(id_reg_dst), .id_alu_src(id_alu_src),
        .id_alu_op(id_alu_op), .id_func(id_func), .id_shamt(id_shamt),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2),
        .id_imm_ext(id_imm_ext), .id_pc4(id_pc4),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_dst(ex_reg_dst), .ex_alu_src(ex_alu_src),
        .ex_alu_op(ex_alu_op), .ex_func(ex_func), .ex_shamt(ex_shamt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2),
        .ex_imm_ext(ex_imm_ext), .ex_pc4(ex_pc4)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Every control field reads as a bubble.
    task automatic chk_bubble(input string tag);
        chk({tag, ".valid"},     ex_valid,      0);
        chk({tag, ".reg_write"}, ex_reg_write,  0);
        chk({tag, ".mem_to_reg"},ex_mem_to_reg, 0);
        chk({tag, ".branch"},    ex_branch,     0);
        chk({tag, ".mem_read"},  ex_mem_read,   0);
        chk({tag, ".mem_write"}, ex_mem_write,  0);
        chk({tag, ".reg_dst"},   ex_reg_dst,    0);
        chk({tag, ".alu_src"},   ex_alu_src,    0);
        chk({tag, ".alu_op"},    ex_alu_op,     0);
    endtask

    task automatic chk_data_zero(input string tag);
        chk({tag, ".func"},   ex_func,    0);
        chk({tag, ".shamt"},  ex_shamt,   0);
        chk({tag, ".rs"},     ex_rs,      0);
        chk({tag, ".rt"},     ex_rt,      0);
        chk({tag, ".rd"},     ex_rd,      0);
        chk({tag, ".rdata1"}, ex_rdata1,  0);
        chk({tag, ".rdata2"}, ex_rdata2,  0);
        chk({tag, ".imm"},    ex_imm_ext, 0);
        chk({tag, ".pc4"},    ex_pc4,     0);
    endtask

    task automatic clr_id();
        id_valid = 0; id_reg_write = 0; id_mem_to_reg = 0; id_branch = 0;
        id_mem_read = 0; id_mem_write = 0; id_reg_dst = 0; id_alu_src = 0;
        id_alu_op = 2'b00; id_func = '0; id_shamt = '0;
        id_rs = '0; id_rt = '0; id_rd = '0;
        id_rdata1 = '0; id_rdata2 = '0; id_imm_ext = '0; id_pc4 = '0;
    endtask

    // Advance one edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 0; stall = 0; flush = 0;
        clr_id();
        id_valid = 1; id_reg_write = 1; id_rdata1 = 32'h1234_5678;
        #1;
        // reset holds outputs at zero regardless of inputs and clock
        chk_bubble("reset");
        chk_data_zero("reset");
        step();
        chk("reset_clk.rdata1", ex_rdata1, 0);
        rst_n = 1;

        // pass-through of an R-type add
        clr_id();
        id_valid = 1; id_alu_op = 2'b10; id_func = 6'b100000;
        id_rdata1 = 32'h5; id_rdata2 = 32'h3; id_reg_write = 1; id_reg_dst = 1;
        id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd3; id_shamt = 5'd7; id_pc4 = 32'h104;
        step();
        chk("pt.alu_op", ex_alu_op, 2'b10);
        chk("pt.func",   ex_func,   6'b100000);
        chk("pt.rdata1", ex_rdata1, 5);
        chk("pt.rdata2", ex_rdata2, 3);
        chk("pt.reg_write", ex_reg_write, 1);
        chk("pt.valid",  ex_valid,  1);
        chk("pt.reg_dst",ex_reg_dst, 1);
        chk("pt.rd",     ex_rd,     3);
        chk("pt.shamt",  ex_shamt,  7);
        chk("pt.pc4",    ex_pc4,    32'h104);

        // load lw then hold through 3 stall cycles with different id_*
        clr_id();
        id_valid = 1; id_alu_op = 2'b00; id_mem_read = 1; id_mem_to_reg = 1;
        id_alu_src = 1; id_reg_write = 1; id_imm_ext = 32'h4; id_rt = 5'd9;
        step();
        chk("lw.mem_read", ex_mem_read, 1);
        stall = 1;
        clr_id();
        id_valid = 1; id_alu_op = 2'b10; id_mem_write = 1; id_imm_ext = 32'hFFFF;
        id_rt = 5'd20; id_func = 6'h2A;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall.imm",      ex_imm_ext,  32'h4);
            chk("stall.alu_op",   ex_alu_op,   2'b00);
            chk("stall.mem_read", ex_mem_read, 1);
            chk("stall.mem_write",ex_mem_write,0);
            chk("stall.rt",       ex_rt,       9);
            chk("stall.func",     ex_func,     0);
        end
        // first non-stall edge takes the values present at that edge
        stall = 0;
        id_imm_ext = 32'h88;
        step();
        chk("unstall.imm",       ex_imm_ext,   32'h88);
        chk("unstall.mem_write", ex_mem_write, 1);
        chk("unstall.alu_op",    ex_alu_op,    2'b10);
        chk("unstall.rt",        ex_rt,        20);

        // beq in EX, then flush
        clr_id();
        id_valid = 1; id_alu_op = 2'b01; id_branch = 1; id_func = 6'h11;
        id_rs = 5'd4; id_rdata1 = 32'hAA;
        step();
        chk("beq.branch", ex_branch, 1);
        chk("beq.alu_op", ex_alu_op, 2'b01);
        flush = 1;
        step();
        flush = 0;
        chk_bubble("flush");
        chk_data_zero("flush");

        // add in EX, then flush and stall together
        clr_id();
        id_valid = 1; id_alu_op = 2'b10; id_func = 6'b100000; id_reg_write = 1;
        id_rdata1 = 32'h11; id_rd = 5'd5;
        step();
        chk("add.reg_write", ex_reg_write, 1);
        stall = 1; flush = 1;
        step();
        stall = 0; flush = 0;
        chk_bubble("flush_stall");
        chk_data_zero("flush_stall");

        // async reset between edges
        clr_id();
        id_valid = 1; id_reg_write = 1; id_rdata1 = 32'hDEADBEEF;
        step();
        chk("pre_rst.rdata1",    ex_rdata1,    32'hDEADBEEF);
        chk("pre_rst.reg_write", ex_reg_write, 1);
        #2;
        stall = 1; flush = 1;
        rst_n = 0;
        #1;
        chk_bubble("async_rst");
        chk_data_zero("async_rst");
        @(negedge clk);
        rst_n = 1; stall = 0; flush = 0;
        id_rdata1 = 32'hCAFE0001; id_alu_op = 2'b10;
        step();
        chk("post_rst.rdata1",   ex_rdata1,    32'hCAFE0001);
        chk("post_rst.valid",    ex_valid,     1);
        chk("post_rst.alu_op",   ex_alu_op,    2'b10);

        // invalid decode: controls forced to bubble, data passes through
        clr_id();
        id_valid = 0; id_reg_write = 1; id_mem_write = 1; id_branch = 1;
        id_alu_op = 2'b10; id_rdata2 = 32'h77; id_pc4 = 32'h200;
        step();
        chk_bubble("invalid");
        chk("invalid.rdata2", ex_rdata2, 32'h77);
        chk("invalid.pc4",    ex_pc4,    32'h200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Write-enables must never be seen on an invalid slot.
    always @(negedge clk) begin
        if (rst_n && !ex_valid && (ex_reg_write || ex_mem_write)) begin
            n_tests++;
            n_fail++;
            $display("FAIL wen_invalid: reg_write=%0b mem_write=%0b valid=0 expected no write enable",
                     ex_reg_write, ex_mem_write);
        end
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation still running at %0t, expected finish", $time);
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1);
    end
endmodule
